// File: rtl/bias_preload_fifo.sv
// AXI4-Stream slave front end and first-word-fall-through preload FIFO for the bias path.
// Optional stream framing check is enabled with `define BIAS_PRELOAD_TLAST_CHECK_EN.
module bias_preload_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 16,
    parameter int bit_num    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  transfer_start,
    input  logic                  write_en,
    input  logic [11:0]           output_channel_size,
    input  logic                  axis_fifo_read,
    output logic [DATA_WIDTH-1:0] bias_from_preload,
    output logic [bit_num:0]      axis_fifo_cnt,
    output logic                  wait_input_from_axis,
    output logic                  preload_done,
    output logic                  tlast_err
);

    localparam logic [bit_num:0] FULL_CNT = (bit_num+1)'(FIFO_SIZE);

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    logic [bit_num-1:0]    wr_ptr;
    logic [bit_num-1:0]    rd_ptr;
    logic [bit_num:0]      cnt;
    logic [11:0]           beat_cnt;
    logic                  active;
    logic                  session_start;
    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic                  last_beat;

    assign session_start = transfer_start && write_en;
    assign not_empty     = (cnt != '0);
    assign s_axis_tready = active && write_en && (cnt != FULL_CNT) && !preload_done;
    // transfer_start (either flavour) suppresses any push or pop in its cycle
    assign push          = s_axis_tvalid && s_axis_tready && !transfer_start;
    assign pop           = axis_fifo_read && not_empty && !transfer_start;
    assign last_beat     = (beat_cnt + 12'd1 == output_channel_size) && (output_channel_size != 12'd0);

    assign bias_from_preload    = not_empty ? mem[rd_ptr] : '0;
    assign axis_fifo_cnt        = cnt;
    assign wait_input_from_axis = not_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            beat_cnt     <= '0;
            active       <= 1'b0;
            preload_done <= 1'b0;
        end else if (session_start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            beat_cnt     <= '0;
            active       <= 1'b1;
            preload_done <= 1'b0;
        end else if (transfer_start) begin
            active <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= beat_cnt + 12'd1;
                if (last_beat) begin
                    preload_done <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // a pop while empty is already masked, so push+pop always nets zero
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef BIAS_PRELOAD_TLAST_CHECK_EN
    logic [11:0] last_idx;
    logic        framing_bad;

    assign last_idx    = output_channel_size - 12'd1;
    assign framing_bad = (s_axis_tlast && (beat_cnt != last_idx)) ||
                         (!s_axis_tlast && last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlast_err <= 1'b0;
        end else if (session_start) begin
            tlast_err <= 1'b0;
        end else if (push && framing_bad) begin
            tlast_err <= 1'b1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign tlast_err    = 1'b0;
`endif

endmodule
